// File: rtl/rst_seq.sv
// Reset sequencer: holds all resets, waits for memory, then releases the
// memory, bus and cpu resets in that order.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   HOLD     | all resets asserted for HOLD_CYCLES edges
//   WAIT_MEM | memory released; waiting for mem_ready (bounded)
//   GAP      | bus released; cpu held for STAGE_GAP edges
//   RUN      | all resets released; sw_rst_req / wdog_exp restart
module rst_seq #(
   parameter int unsigned HOLD_CYCLES = 16,
   parameter int unsigned STAGE_GAP   = 8,
   parameter int unsigned ACK_TIMEOUT = 200
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sw_rst_req,
   input  logic       wdog_exp,
   input  logic       mem_ready,
   output logic       rst_mem,
   output logic       rst_bus,
   output logic       rst_cpu,
   output logic       busy,
   output logic [1:0] rst_cause
);

   typedef enum logic [1:0] {
      HOLD     = 2'd0,
      WAIT_MEM = 2'd1,
      GAP      = 2'd2,
      RUN      = 2'd3
   } state_t;

   localparam logic [1:0] CAUSE_EXT  = 2'b00;
   localparam logic [1:0] CAUSE_SW   = 2'b01;
   localparam logic [1:0] CAUSE_WDOG = 2'b10;
   localparam logic [1:0] CAUSE_MEM  = 2'b11;

   // Terminal counts: cnt is compared before incrementing, so it never wraps.
   localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
   localparam logic [7:0] GAP_LAST  = 8'(STAGE_GAP - 1);
   localparam logic [7:0] ACK_LAST  = 8'(ACK_TIMEOUT - 1);

   state_t     state, state_nxt;
   logic [7:0] cnt, cnt_nxt;
   logic [1:0] cause_nxt;

   // State, counter, cause and output registers; outputs decode the next
   // state so each reset changes exactly on the transition edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= HOLD;
         cnt       <= 8'd0;
         rst_cause <= CAUSE_EXT;
         rst_mem   <= 1'b1;
         rst_bus   <= 1'b1;
         rst_cpu   <= 1'b1;
         busy      <= 1'b1;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         rst_cause <= cause_nxt;
         rst_mem   <= (state_nxt == HOLD);
         rst_bus   <= (state_nxt == HOLD) || (state_nxt == WAIT_MEM);
         rst_cpu   <= (state_nxt != RUN);
         busy      <= (state_nxt != RUN);
      end
   end

   // Next-state and counter logic; mem_ready beats a coincident timeout,
   // wdog_exp beats a coincident sw_rst_req.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + 8'd1;
      cause_nxt = rst_cause;
      unique case (state)
         HOLD: begin
            if (cnt == HOLD_LAST) begin
               state_nxt = WAIT_MEM;
               cnt_nxt   = 8'd0;
            end
         end
         WAIT_MEM: begin
            if (mem_ready) begin
               state_nxt = GAP;
               cnt_nxt   = 8'd0;
            end else if (cnt == ACK_LAST) begin
               state_nxt = HOLD;
               cnt_nxt   = 8'd0;
               cause_nxt = CAUSE_MEM;
            end
         end
         GAP: begin
            if (cnt == GAP_LAST) begin
               state_nxt = RUN;
               cnt_nxt   = 8'd0;
            end
         end
         RUN: begin
            cnt_nxt = 8'd0;
            if (wdog_exp) begin
               state_nxt = HOLD;
               cause_nxt = CAUSE_WDOG;
            end else if (sw_rst_req) begin
               state_nxt = HOLD;
               cause_nxt = CAUSE_SW;
            end
         end
         default: begin
            state_nxt = HOLD;
            cnt_nxt   = 8'd0;
         end
      endcase
   end

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq with default parameters. Expected output
// vectors {rst_mem, rst_bus, rst_cpu, busy, rst_cause} are queued when
// stimulus is applied and popped when the DUT outputs are sampled.
module tb_rst_seq;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sw_rst_req = 1'b0;
   logic       wdog_exp = 1'b0;
   logic       mem_ready = 1'b0;
   logic       rst_mem, rst_bus, rst_cpu, busy;
   logic [1:0] rst_cause;

   typedef struct {
      string      tag;
      logic [5:0] val;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   localparam logic [5:0] V_HOLD_EXT = 6'b1111_00;

   rst_seq dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sw_rst_req (sw_rst_req),
      .wdog_exp   (wdog_exp),
      .mem_ready  (mem_ready),
      .rst_mem    (rst_mem),
      .rst_bus    (rst_bus),
      .rst_cpu    (rst_cpu),
      .busy       (busy),
      .rst_cause  (rst_cause)
   );

   always #5 clk = ~clk;

   // Advance n rising edges and settle 1 time unit after the last one.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input string tag, input logic m, input logic b,
                           input logic c, input logic bz, input logic [1:0] cause);
      exp_t e;
      e.tag = tag;
      e.val = {m, b, c, bz, cause};
      exp_q.push_back(e);
   endtask

   task automatic check_out();
      exp_t       e;
      logic [5:0] obs;
      e   = exp_q.pop_front();
      obs = {rst_mem, rst_bus, rst_cpu, busy, rst_cause};
      n_tests++;
      assert (obs === e.val) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b (mem bus cpu busy cause)",
                e.tag, obs, e.val);
      end
   endtask

   task automatic expect_now(input string tag, input logic m, input logic b,
                             input logic c, input logic bz, input logic [1:0] cause);
      push_exp(tag, m, b, c, bz, cause);
      check_out();
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      // Cold start, mem_ready tied high
      mem_ready = 1'b1;
      #23;
      expect_now("reset_state", 1, 1, 1, 1, 2'b00);
      release_reset();
      tick(15);
      expect_now("cold_e15_hold", 1, 1, 1, 1, 2'b00);
      tick(1);
      expect_now("cold_e16_mem_rel", 0, 1, 1, 1, 2'b00);
      tick(1);
      expect_now("cold_e17_bus_rel", 0, 0, 1, 1, 2'b00);
      tick(7);
      expect_now("cold_e24_cpu_held", 0, 0, 1, 1, 2'b00);
      tick(1);
      expect_now("cold_e25_run", 0, 0, 0, 0, 2'b00);
      tick(5);
      expect_now("run_stable", 0, 0, 0, 0, 2'b00);

      // Simultaneous sw_rst_req and wdog_exp in RUN: watchdog wins
      sw_rst_req = 1'b1;
      wdog_exp   = 1'b1;
      tick(1);
      sw_rst_req = 1'b0;
      wdog_exp   = 1'b0;
      expect_now("both_req_wdog_wins", 1, 1, 1, 1, 2'b10);
      tick(16);
      expect_now("wdog_seq_mem_rel", 0, 1, 1, 1, 2'b10);
      tick(1);
      expect_now("wdog_seq_bus_rel", 0, 0, 1, 1, 2'b10);
      tick(8);
      expect_now("wdog_seq_run", 0, 0, 0, 0, 2'b10);

      // Late mem_ready at edge 40, plus requests ignored during GAP
      rst_n     = 1'b0;
      mem_ready = 1'b0;
      #2;
      expect_now("rst_in_run_async", 1, 1, 1, 1, 2'b00);
      release_reset();
      tick(39);
      expect_now("late_e39_wait", 0, 1, 1, 1, 2'b00);
      mem_ready = 1'b1;
      tick(1);
      expect_now("late_e40_bus_rel", 0, 0, 1, 1, 2'b00);
      tick(2);
      sw_rst_req = 1'b1;
      wdog_exp   = 1'b1;
      tick(1);
      sw_rst_req = 1'b0;
      wdog_exp   = 1'b0;
      expect_now("gap_req_ignored", 0, 0, 1, 1, 2'b00);
      tick(4);
      expect_now("late_e47_cpu_held", 0, 0, 1, 1, 2'b00);
      tick(1);
      expect_now("late_e48_run", 0, 0, 0, 0, 2'b00);
      // mem_ready is ignored in RUN
      mem_ready = 1'b0;
      tick(3);
      expect_now("run_ignores_mem_ready", 0, 0, 0, 0, 2'b00);
      sw_rst_req = 1'b1;
      tick(1);
      sw_rst_req = 1'b0;
      expect_now("sw_req_in_run", 1, 1, 1, 1, 2'b01);

      // Memory timeout with mem_ready held low, then recovery
      tick(16);
      expect_now("to_mem_rel", 0, 1, 1, 1, 2'b01);
      tick(199);
      expect_now("to_wait_199", 0, 1, 1, 1, 2'b01);
      tick(1);
      expect_now("to_reassert", 1, 1, 1, 1, 2'b11);
      mem_ready = 1'b1;
      tick(15);
      expect_now("to_rehold_e15", 1, 1, 1, 1, 2'b11);
      tick(1);
      expect_now("to_rehold_mem_rel", 0, 1, 1, 1, 2'b11);
      tick(1);
      expect_now("to_rehold_bus_rel", 0, 0, 1, 1, 2'b11);
      tick(8);
      expect_now("to_recover_run", 0, 0, 0, 0, 2'b11);

      // Watchdog alone in RUN
      wdog_exp = 1'b1;
      tick(1);
      wdog_exp = 1'b0;
      expect_now("wdog_alone", 1, 1, 1, 1, 2'b10);

      // rst_n asserted mid-WAIT_MEM, between clock edges
      mem_ready = 1'b0;
      tick(16 + 50);
      expect_now("mid_wait", 0, 1, 1, 1, 2'b10);
      #3;
      rst_n = 1'b0;
      #1;
      expect_now("async_abort", 1, 1, 1, 1, 2'b00);
      mem_ready = 1'b1;
      release_reset();
      tick(15);
      expect_now("restart_e15", 1, 1, 1, 1, 2'b00);
      tick(1);
      expect_now("restart_e16", 0, 1, 1, 1, 2'b00);
      tick(1);
      expect_now("restart_e17", 0, 0, 1, 1, 2'b00);
      tick(8);
      expect_now("restart_e25", 0, 0, 0, 0, 2'b00);

      // mem_ready on the same edge as the timeout: mem_ready wins
      rst_n     = 1'b0;
      mem_ready = 1'b0;
      #2;
      expect_now("rst_again", V_HOLD_EXT[5], V_HOLD_EXT[4], V_HOLD_EXT[3],
                 V_HOLD_EXT[2], V_HOLD_EXT[1:0]);
      release_reset();
      tick(16 + 199);
      mem_ready = 1'b1;
      tick(1);
      expect_now("timeout_tie_mem_wins", 0, 0, 1, 1, 2'b00);
      tick(8);
      expect_now("tie_run", 0, 0, 0, 0, 2'b00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rst_seq.md
RST_SEQ -- requirements
Module: rst_seq

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 16: cycles all reset outputs are held asserted in HOLD, range 2..255.
REQ-002 SHALL have parameter STAGE_GAP, default 8: cycles between rst_bus release and rst_cpu release, range 1..255.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 200: maximum cycles to wait for mem_ready, range 1..255.
REQ-004 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port sw_rst_req, input, 1: software reset request, synchronous to clk, sampled only in RUN.
REQ-007 SHALL have port wdog_exp, input, 1: watchdog expiry, synchronous to clk, sampled only in RUN.
REQ-008 SHALL have port mem_ready, input, 1: memory subsystem initialised; level, synchronous to clk.
REQ-009 SHALL have port rst_mem, output, 1: active-high reset to the memory subsystem, registered.
REQ-010 SHALL have port rst_bus, output, 1: active-high reset to the bus and peripherals, registered.
REQ-011 SHALL have port rst_cpu, output, 1: active-high reset to the CPU, registered.
REQ-012 SHALL have port busy, output, 1: high whenever state is not RUN, registered.
REQ-013 SHALL have port rst_cause, output, 2: cause of the last sequence; 00 external, 01 software, 10 watchdog, 11 memory timeout.

Function
REQ-014 SHALL implement states HOLD, WAIT_MEM, GAP, RUN, driven by one 8-bit cycle counter cnt.
- Edge 1 is the first rising clk edge with rst_n high.
REQ-015 HOLD SHALL assert all three resets and increment cnt each edge.
- When cnt == HOLD_CYCLES-1: go to WAIT_MEM, clear cnt.
- rst_mem therefore falls after edge HOLD_CYCLES.
REQ-016 WAIT_MEM SHALL drive rst_mem=0, rst_bus=1, rst_cpu=1.
- mem_ready sampled 1: go to GAP, clear cnt; rst_bus falls at that edge.
- Otherwise increment cnt.
REQ-017 In WAIT_MEM, if cnt == ACK_TIMEOUT-1 and mem_ready is 0, SHALL go to HOLD, clear cnt, set rst_cause=11, and reassert all resets at that edge.
REQ-018 If mem_ready is 1 on the same edge as the timeout, mem_ready SHALL win and the block SHALL go to GAP.
REQ-019 GAP SHALL drive rst_mem=0, rst_bus=0, rst_cpu=1 and increment cnt.
- When cnt == STAGE_GAP-1: go to RUN; rst_cpu falls and busy falls at that edge.
REQ-020 RUN SHALL drive all resets 0 and busy 0.
- mem_ready is ignored in RUN.
REQ-021 In RUN, wdog_exp=1 SHALL cause, at that edge: go to HOLD, clear cnt, rst_cause=10, all resets and busy asserted.
REQ-022 In RUN, sw_rst_req=1 with wdog_exp=0 SHALL behave as REQ-021 with rst_cause=01.
- If both are high, wdog_exp wins and rst_cause=10.
REQ-023 sw_rst_req and wdog_exp SHALL be ignored in HOLD, WAIT_MEM and GAP; the sequence is not restarted or extended.
REQ-024 Reset outputs SHALL be released strictly in order mem, bus, cpu, and asserted simultaneously; no other ordering SHALL be observable.
REQ-025 rst_cause SHALL change only on entry to HOLD and SHALL hold its value through RUN.
REQ-026 cnt SHALL never wrap: it is cleared on every state change and compared against parameter-1 before incrementing.

Reset
REQ-027 rst_n low SHALL immediately, without a clock edge, force state HOLD, cnt=0, rst_mem=rst_bus=rst_cpu=1, busy=1, rst_cause=00.
REQ-028 rst_n asserted in any state, including mid-sequence, SHALL abort the sequence and restart from REQ-015 after deassertion.
REQ-029 rst_n deassertion SHALL be assumed synchronised externally to clk; the block SHALL add no synchroniser.

Verification
REQ-030 Cold start with defaults, mem_ready tied 1:
- rst_mem falls after edge 16.
- rst_bus falls after edge 17.
- rst_cpu and busy fall after edge 25.
- rst_cause=00.
REQ-031 Cold start, mem_ready rises at edge 40:
- rst_bus falls after edge 40.
- rst_cpu falls after edge 48.
REQ-032 mem_ready held 0:
- Timeout after WAIT_MEM edge 200: all resets reassert, rst_cause=11.
- Sequence repeats; then mem_ready=1 completes it with rst_cause still 11.
REQ-033 In RUN, pulse sw_rst_req and wdog_exp in the same cycle:
- All resets assert at that edge, rst_cause=10.
- Full sequence repeats.
REQ-034 Pulse sw_rst_req during GAP:
- No effect; rst_cpu falls on schedule, rst_cause unchanged.
- A later sw_rst_req in RUN gives rst_cause=01.
REQ-035 Assert rst_n mid-WAIT_MEM, between clock edges:
- Outputs go to reset values asynchronously, rst_cause=00.
- Restart timing after release matches REQ-030.
